data_memory_io: RTL and testbench
=================================

DATA_MEMORY_IO -- requirements
Module: data_memory_io

Interface
REQ-001 Parameter RAM_SIZE_BIT, default 8, meaning RAM holds 2^RAM_SIZE_BIT 32-bit words.
REQ-002 Parameter LED_WIDTH, default 8, meaning width of LED register (1..32).
REQ-003 Parameter DIGI_WIDTH, default 12, meaning width of 7-segment register (1..32).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-006 Address  input  32  byte address; bits [1:0] ignored.
REQ-007 Write_data  input  32  store data.
REQ-008 ByteEn  input  4  RAM byte lane write enables; bit n gates Write_data[8n+7:8n].
REQ-009 MemRead  input  1  read strobe.
REQ-010 MemWrite  input  1  write strobe.
REQ-011 Read_data  output  32  load data, combinational.
REQ-012 led  output  LED_WIDTH  LED register.
REQ-013 digi  output  DIGI_WIDTH  7-segment register.
REQ-014 irq  output  1  timer interrupt request, equal to TCON[2].

Function
REQ-015 Address[31:28]==4'h4 SHALL select the MMIO region; any other address SHALL select RAM word Address[RAM_SIZE_BIT+1:2] (upper bits alias).
REQ-016 MMIO map (word offsets from 0x40000000): 0x00 TH, 0x04 TL, 0x08 TCON, 0x0C led, 0x10 digi, 0x14 systick; other MMIO addresses SHALL read 0 and ignore writes.
REQ-017 Read_data SHALL be 0 when MemRead=0, else the addressed value: RAM word, TH, TL, {29'b0,TCON[2:0]}, zero-extended led, zero-extended digi, systick.
REQ-018 RAM write: MemWrite=1 SHALL update only lanes with ByteEn bit set, visible on Read_data the cycle after the edge.
REQ-019 MMIO writes SHALL be full-word, ByteEn ignored; led/digi take Write_data[LED_WIDTH-1:0]/[DIGI_WIDTH-1:0].
REQ-020 TCON bits: [0] enable, [1] interrupt enable, [2] status; write sets [1:0] from Write_data[1:0] and [2] to Write_data[2] AND old [2] (software can only clear).
REQ-021 Timer: with TCON[0]=1, TL SHALL increment by 1 each cycle; when TL==32'hFFFFFFFF, next TL SHALL be TH (reload), not 0.
REQ-022 On reload with TCON[1]=1, TCON[2] SHALL be set the same edge; irq SHALL go high the following cycle and hold until cleared.
REQ-023 Reload with TCON[1]=0 SHALL not set TCON[2].
REQ-024 systick SHALL increment every cycle unconditionally, wrap 0xFFFFFFFF->0, writes ignored.
REQ-025 Simultaneous software write to TL and timer increment/reload: software value SHALL win.
REQ-026 Simultaneous TCON write clearing [2] and reload setting it: TCON[2] SHALL be 1.
REQ-027 Simultaneous TH write and reload: TL SHALL load the old TH.
REQ-028 MemRead and MemWrite both high: Read_data SHALL show pre-write contents for that cycle.

Reset
REQ-029 reset=0 at a rising edge SHALL clear all RAM words, TH, TL, TCON, led, digi, systick to 0; irq=0 the next cycle.
REQ-030 Reset SHALL override any concurrent MemWrite or timer event; asserting mid-count SHALL abort the count with no irq.
REQ-031 Read_data stays combinational during reset and SHALL reflect cleared state after the reset edge.

Verification
REQ-032 Write 0x11223344 to 0x00000010 with ByteEn=4'b0101, prior contents 0xAABBCCDD -> read 0x00000010 returns 0xAA22CC44; read 0x00000410 (alias, RAM_SIZE_BIT=8) returns same.
REQ-033 TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3 -> TL 0xFFFFFFFF, then 0xFFFFFFFD with TCON reading 7, irq=1 next cycle; write TCON=3 -> irq=0.
REQ-034 Reload edge coincides with TCON write of 3 -> TCON reads 7, irq stays 1.
REQ-035 Write led=0x1A5, digi=0xFABC (defaults) -> led=0xA5, digi=0xABC; read 0x4000000C=0x000000A5; read 0x40000018=0.
REQ-036 Run 10 cycles after reset -> systick reads 10; assert reset with TL counting -> all MMIO read 0, irq=0.

Source files
------------

// File: rtl/data_memory_io.sv
// Data memory with memory-mapped I/O: a word RAM with byte-lane writes plus a
// small MMIO block (reloading timer, LED and 7-segment registers, free-running
// systick). Loads are combinational; all state changes on the rising clock edge.
module data_memory_io #(
    parameter int RAM_SIZE_BIT = 8,
    parameter int LED_WIDTH    = 8,
    parameter int DIGI_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Address,
    input  logic [31:0]           Write_data,
    input  logic [3:0]            ByteEn,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    output logic [31:0]           Read_data,
    output logic [LED_WIDTH-1:0]  led,
    output logic [DIGI_WIDTH-1:0] digi,
    output logic                  irq
);

    localparam int RAM_WORDS = 1 << RAM_SIZE_BIT;

    // Word offsets (Address[27:2]) of the MMIO registers.
    localparam logic [25:0] OFF_TH      = 26'h0;
    localparam logic [25:0] OFF_TL      = 26'h1;
    localparam logic [25:0] OFF_TCON    = 26'h2;
    localparam logic [25:0] OFF_LED     = 26'h3;
    localparam logic [25:0] OFF_DIGI    = 26'h4;
    localparam logic [25:0] OFF_SYSTICK = 26'h5;

    logic [31:0]             ram [0:RAM_WORDS-1];
    logic [31:0]             th;
    logic [31:0]             tl;
    logic [2:0]              tcon;
    logic [31:0]             systick;

    logic                    is_mmio;
    logic [25:0]             mmio_off;
    logic [RAM_SIZE_BIT-1:0] ram_idx;
    logic                    ram_we;
    logic                    we_th, we_tl, we_tcon, we_led, we_digi;
    logic                    reload;
    logic [31:0]             tl_next;
    logic [2:0]              tcon_next;

    // Byte-select bits never take part in decoding.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Address[1:0];

    assign is_mmio  = (Address[31:28] == 4'h4);
    assign mmio_off = Address[27:2];
    assign ram_idx  = Address[RAM_SIZE_BIT+1:2];
    assign ram_we   = MemWrite && !is_mmio;
    assign we_th    = MemWrite && is_mmio && (mmio_off == OFF_TH);
    assign we_tl    = MemWrite && is_mmio && (mmio_off == OFF_TL);
    assign we_tcon  = MemWrite && is_mmio && (mmio_off == OFF_TCON);
    assign we_led   = MemWrite && is_mmio && (mmio_off == OFF_LED);
    assign we_digi  = MemWrite && is_mmio && (mmio_off == OFF_DIGI);
    assign irq      = tcon[2];

    // Timer next state: count/reload, then let software writes take priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        tl_next   = tl;
        tcon_next = tcon;
        reload    = tcon[0] && (&tl);
        if (tcon[0]) begin
            tl_next = reload ? th : tl + 32'd1;
        end
        if (we_tl) begin
            tl_next = Write_data;
        end
        if (we_tcon) begin
            // Software may clear the status bit but never set it.
            tcon_next = {Write_data[2] & tcon[2], Write_data[1:0]};
        end
        // A reload's status set beats a concurrent software clear.
        if (reload && tcon[1]) begin
            tcon_next[2] = 1'b1;
        end
    end

    // RAM storage: cleared on reset, byte-lane writes otherwise.
    always_ff @(posedge clk) begin
        // NOTE: the memory reset is functional (every word must read 0 after reset), so it is built from flops, not block RAM.
        if (!reset) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
                ram[i] <= '0;
            end
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ByteEn[b]) begin
                    ram[ram_idx][8*b +: 8] <= Write_data[8*b +: 8];
                end
            end
        end
    end

    // MMIO registers and the free-running systick.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            led     <= '0;
            digi    <= '0;
            systick <= '0;
        end else begin
            tl      <= tl_next;
            tcon    <= tcon_next;
            systick <= systick + 32'd1;
            if (we_th)   th   <= Write_data;
            if (we_led)  led  <= Write_data[LED_WIDTH-1:0];
            if (we_digi) digi <= Write_data[DIGI_WIDTH-1:0];
        end
    end

    // Combinational load path; returns 0 whenever no read is requested.
    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (is_mmio) begin
                case (mmio_off)
                    OFF_TH:      Read_data = th;
                    OFF_TL:      Read_data = tl;
                    OFF_TCON:    Read_data = {29'b0, tcon};
                    OFF_LED:     Read_data[LED_WIDTH-1:0] = led;
                    OFF_DIGI:    Read_data[DIGI_WIDTH-1:0] = digi;
                    OFF_SYSTICK: Read_data = systick;
                    default:     Read_data = '0;
                endcase
            end else begin
                Read_data = ram[ram_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_io.sv
// Self-checking bench for data_memory_io: table of RAM write/read vectors plus
// hand-written timer, MMIO and reset sequences.
module tb_data_memory_io;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [3:0]  ByteEn;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    data_memory_io #(.RAM_SIZE_BIT(8), .LED_WIDTH(8), .DIGI_WIDTH(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .ByteEn     (ByteEn),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .led        (led),
        .digi       (digi),
        .irq        (irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        Address    = a;
        Write_data = d;
        ByteEn     = be;
        MemWrite   = 1'b1;
        cycle();
        MemWrite   = 1'b0;
        ByteEn     = 4'h0;
    endtask

    task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
        Address = a;
        MemRead = 1'b1;
        #1;
        check(name, Read_data, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0010, 32'hAABB_CCDD, 4'hF, 32'h0000_0010, 32'hAABB_CCDD};
        vecs[1] = '{32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0000_0010, 32'hAA22_CC44};
        vecs[2] = '{32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0410, 32'hAA22_CC44};
        vecs[3] = '{32'h0000_03FC, 32'hDEAD_BEEF, 4'hF, 32'h0000_03FF, 32'hDEAD_BEEF};
        vecs[4] = '{32'h0000_0020, 32'h1234_5678, 4'hA, 32'h0000_0020, 32'h1200_5600};
        vecs[5] = '{32'h8000_0024, 32'hCAFE_F00D, 4'hC, 32'h0000_0024, 32'hCAFE_0000};
        vecs[6] = '{32'h4000_001C, 32'hFFFF_FFFF, 4'hF, 32'h0000_001C, 32'h0000_0000};

        reset = 1'b0; Address = '0; Write_data = '0; ByteEn = '0;
        MemRead = 1'b0; MemWrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_led", {24'b0, led}, 32'h0);
        check("rst_digi", {20'b0, digi}, 32'h0);
        read_check(A_TL, 32'h0, "rst_tl");
        read_check(A_TCON, 32'h0, "rst_tcon");
        read_check(32'h10, 32'h0, "rst_ram");

        // Systick counts edges after release
        reset = 1'b1;
        repeat (10) cycle();
        read_check(A_TICK, 32'd10, "systick_10");

        // RAM byte-lane vectors
        for (int i = 0; i < 7; i++) begin
            write_word(vecs[i].waddr, vecs[i].wdata, vecs[i].be);
            read_check(vecs[i].raddr, vecs[i].exp, $sformatf("ram_vec%0d", i));
        end

        // Read and write in the same cycle: pre-write contents visible
        Address = 32'h10; Write_data = 32'h5555_5555; ByteEn = 4'hF;
        MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        check("rw_same_pre", Read_data, 32'hAA22_CC44);
        cycle();
        check("rw_same_post", Read_data, 32'h5555_5555);
        MemWrite = 1'b0; MemRead = 1'b0; ByteEn = 4'h0;
        #1;
        check("no_read_zero", Read_data, 32'h0);

        // LED / 7-segment, ByteEn ignored for MMIO
        write_word(A_LED, 32'h0000_01A5, 4'h0);
        write_word(A_DIGI, 32'h0000_FABC, 4'h1);
        check("led_out", {24'b0, led}, 32'hA5);
        check("digi_out", {20'b0, digi}, 32'hABC);
        read_check(A_LED, 32'h0000_00A5, "led_read");
        read_check(A_DIGI, 32'h0000_0ABC, "digi_read");
        read_check(32'h4000_0018, 32'h0, "mmio_unmapped");
        read_check(32'h0, 32'h0, "mmio_no_ram_write");

        // Timer reload with interrupt
        write_word(A_TH, 32'hFFFF_FFFD, 4'hF);
        write_word(A_TL, 32'hFFFF_FFFE, 4'hF);
        write_word(A_TCON, 32'h3, 4'hF);
        read_check(A_TL, 32'hFFFF_FFFE, "tmr_start");
        cycle();
        read_check(A_TL, 32'hFFFF_FFFF, "tmr_max");
        check("tmr_irq_before", {31'b0, irq}, 32'h0);
        cycle();
        read_check(A_TL, 32'hFFFF_FFFD, "tmr_reload");
        read_check(A_TCON, 32'h7, "tmr_tcon7");
        check("tmr_irq_set", {31'b0, irq}, 32'h1);
        write_word(A_TCON, 32'h3, 4'hF);
        check("tmr_irq_clr", {31'b0, irq}, 32'h0);
        read_check(A_TL, 32'hFFFF_FFFE, "tmr_after_clr");

        // TCON clear coincides with reload: status wins
        cycle();
        read_check(A_TL, 32'hFFFF_FFFF, "coinc_max");
        write_word(A_TCON, 32'h3, 4'hF);
        read_check(A_TCON, 32'h7, "coinc_tcon");
        check("coinc_irq", {31'b0, irq}, 32'h1);
        read_check(A_TL, 32'hFFFF_FFFD, "coinc_tl");

        // TH write coincides with reload: old TH loaded
        write_word(A_TCON, 32'h3, 4'hF);
        cycle();
        write_word(A_TH, 32'h1234_5678, 4'hF);
        read_check(A_TL, 32'hFFFF_FFFD, "th_coinc_tl");
        read_check(A_TH, 32'h1234_5678, "th_coinc_th");

        // Software TL write beats increment
        write_word(A_TL, 32'h100, 4'hF);
        read_check(A_TL, 32'h100, "tl_write_wins");
        cycle();
        read_check(A_TL, 32'h101, "tl_incr");

        // Reload without interrupt enable
        write_word(A_TCON, 32'h1, 4'hF);
        check("noie_irq_clr", {31'b0, irq}, 32'h0);
        write_word(A_TL, 32'hFFFF_FFFF, 4'hF);
        cycle();
        read_check(A_TL, 32'h1234_5678, "noie_reload");
        read_check(A_TCON, 32'h1, "noie_tcon");
        check("noie_irq", {31'b0, irq}, 32'h0);

        // Reset mid-count overrides a concurrent write
        write_word(A_TCON, 32'h3, 4'hF);
        reset = 1'b0;
        Address = A_LED; Write_data = 32'h3C; ByteEn = 4'hF; MemWrite = 1'b1;
        cycle();
        MemWrite = 1'b0; ByteEn = 4'h0;
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        check("mid_rst_led", {24'b0, led}, 32'h0);
        read_check(A_TH, 32'h0, "mid_rst_th");
        read_check(A_TL, 32'h0, "mid_rst_tl");
        read_check(A_TCON, 32'h0, "mid_rst_tcon");
        read_check(A_DIGI, 32'h0, "mid_rst_digi");
        read_check(A_TICK, 32'h0, "mid_rst_tick");
        read_check(32'h10, 32'h0, "mid_rst_ram");
        reset = 1'b1;
        repeat (3) cycle();
        read_check(A_TL, 32'h0, "post_rst_tl_idle");
        check("post_rst_irq", {31'b0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
